b_resp_arbiter: RTL and testbench

Master-side write-response scheduler for the crossbar. It shares one AXI B channel toward a master among NUM_SRC per-slave B-response FIFOs. Each FIFO is a first-word-fall-through FIFO whose front entry is presented together with an empty flag. The block picks a non-empty FIFO by round-robin, pops it into a one-entry output register, and holds BVALID/BID/BRESP stable until the master accepts. It also counts error responses delivered to the master.

---
 rtl/xbar_pkg.sv | 20 ++
 rtl/rr_picker.sv | 38 +++
 rtl/b_resp_arbiter.sv | 94 +++++++++
 tb/tb_b_resp_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: AXI response codes, output-register states, index-width helper.
// Imported by the B/AW/AR schedulers and their round-robin pickers.
package xbar_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Width of a binary index over n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin first-one search starting at ptr and wrapping modulo NUM_SRC.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_picker #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDX_W-1:0]   sel,
  output logic               any
);

  logic found;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return IDX_W'(s);
  endfunction

  always_comb begin
    gnt   = '0;
    sel   = '0;
    found = 1'b0;
    any   = |req;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && req[wrap_add(ptr, k)]) begin
        found               = 1'b1;
        gnt[wrap_add(ptr, k)] = 1'b1;
        sel                 = wrap_add(ptr, k);
      end
    end
  end

endmodule

// File: rtl/b_resp_arbiter.sv
// Shares one AXI B channel among NUM_SRC FWFT response FIFOs, round-robin, and counts error responses.
// Latency: one cycle from a non-empty FIFO front to BVALID; one response per cycle sustained.
// Backpressure: while BVALID is held without BREADY nothing is popped and the grant stays locked.
module b_resp_arbiter
  import xbar_pkg::*;
#(
  parameter int ID_WIDTH  = 4,
  parameter int NUM_SRC   = 4,
  parameter int CNT_WIDTH = 8,
  localparam int IDX_W    = idx_width(NUM_SRC)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_empty,
  input  logic [NUM_SRC*ID_WIDTH-1:0]  src_BID,
  input  logic [NUM_SRC*2-1:0]         src_BRESP,
  output logic [NUM_SRC-1:0]           src_pop,
  output logic                         BVALID,
  output logic [ID_WIDTH-1:0]          BID,
  output logic [1:0]                   BRESP,
  input  logic                         BREADY,
  output logic [IDX_W-1:0]             grant_idx,
  output logic [CNT_WIDTH-1:0]         err_cnt
);

  out_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr;
  logic [NUM_SRC-1:0]  req, gnt;
  logic [IDX_W-1:0]    sel;
  logic                any, free, load, err_hs;
  logic [ID_WIDTH-1:0] sel_bid;
  logic [1:0]          sel_resp;

  assign req    = ~src_empty;
  assign BVALID = (state_q == OUT_FULL);
  assign free   = !BVALID || BREADY;
  assign load   = free && any;
  // Gating with rst keeps the FIFOs untouched while the block is held in reset.
  assign src_pop = (load && !rst) ? gnt : '0;
  assign err_hs  = BVALID && BREADY && (BRESP == RESP_SLVERR || BRESP == RESP_DECERR);

  rr_picker #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .sel (sel),
    .any (any)
  );

  always_comb begin
    sel_bid  = '0;
    sel_resp = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        sel_bid  = src_BID[i*ID_WIDTH +: ID_WIDTH];
        sel_resp = src_BRESP[i*2 +: 2];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (load)        state_d = OUT_FULL;
    else if (BREADY) state_d = OUT_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= OUT_EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BID       <= '0;
      BRESP     <= '0;
      grant_idx <= '0;
      ptr       <= '0;
    end else if (load) begin
      BID       <= sel_bid;
      BRESP     <= sel_resp;
      grant_idx <= sel;
      ptr       <= (sel == IDX_W'(NUM_SRC-1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           err_cnt <= '0;
    else if (err_hs && err_cnt != '1)  err_cnt <= err_cnt + 1'b1;
  end

endmodule

// File: tb/tb_b_resp_arbiter.sv
// Directed bench for b_resp_arbiter with a queue-level reference model checked every cycle.
module tb_b_resp_arbiter;
  import xbar_pkg::*;

  localparam int NS      = 4;
  localparam int IDW     = 4;
  localparam int CW      = 8;
  localparam int IXW     = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [1:0]     resp;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     src_empty;
  logic [NS*IDW-1:0] src_BID;
  logic [NS*2-1:0]   src_BRESP;
  logic [NS-1:0]     src_pop;
  logic              BVALID;
  logic [IDW-1:0]    BID;
  logic [1:0]        BRESP;
  logic              BREADY;
  logic [IXW-1:0]    grant_idx;
  logic [CW-1:0]     err_cnt;

  b_resp_arbiter #(.ID_WIDTH(IDW), .NUM_SRC(NS), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_empty (src_empty),
    .src_BID   (src_BID),
    .src_BRESP (src_BRESP),
    .src_pop   (src_pop),
    .BVALID    (BVALID),
    .BID       (BID),
    .BRESP     (BRESP),
    .BREADY    (BREADY),
    .grant_idx (grant_idx),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  ent_t fq [NS][$];
  int   n_cmp = 0, n_bad = 0;
  int   pop_log[$];
  int   gnt_log[$];
  int   exp_t3[$] = '{3, 1};
  int   exp_t5[$] = '{0, 1, 2, 3, 0, 1, 2, 3};

  // Reference state: what the master should currently see.
  bit   m_valid = 0;
  int   m_id = 0, m_resp = 0, m_gidx = 0, m_ptr = 0, m_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_seq(input string name, input int got[$], input int exp[$]);
    chk({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(name, got[i], exp[i]);
  endtask

  function automatic int pick(input int ptr, input logic [NS-1:0] ne);
    for (int k = 0; k < NS; k++)
      if (ne[(ptr + k) % NS]) return (ptr + k) % NS;
    return -1;
  endfunction

  task automatic drive_fronts();
    for (int i = 0; i < NS; i++) begin
      src_empty[i] = (fq[i].size() == 0);
      src_BID[i*IDW +: IDW] = src_empty[i] ? '0 : fq[i][0].id;
      src_BRESP[i*2 +: 2]   = src_empty[i] ? 2'b00 : fq[i][0].resp;
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_resp = 0; m_gidx = 0; m_ptr = 0; m_err = 0;
  endtask

  // Applies one rising edge to the model using the inputs that were stable before it.
  task automatic model_step();
    bit   hs;
    int   s;
    ent_t e;
    if (rst) begin
      model_reset();
      return;
    end
    hs = m_valid && BREADY;
    s  = (!m_valid || BREADY) ? pick(m_ptr, ~src_empty) : -1;
    if (hs && m_resp >= 2 && m_err < CNT_MAX) m_err++;
    if (s >= 0) begin
      e = fq[s].pop_front();
      m_valid = 1; m_id = e.id; m_resp = e.resp; m_gidx = s; m_ptr = (s + 1) % NS;
    end else if (hs) begin
      m_valid = 0;
    end
  endtask

  task automatic tick();
    drive_fronts();
    @(posedge clk);
    model_step();
    #1;
  endtask

  logic [NS-1:0] exp_pop;
  int            cmp_s;
  always @(negedge clk) begin
    exp_pop = '0;
    if (!rst && (!m_valid || BREADY)) begin
      cmp_s = pick(m_ptr, ~src_empty);
      if (cmp_s >= 0) exp_pop[cmp_s] = 1'b1;
    end
    chk("src_pop",   src_pop,   exp_pop);
    chk("BVALID",    BVALID,    m_valid);
    chk("BID",       BID,       m_id);
    chk("BRESP",     BRESP,     m_resp);
    chk("grant_idx", grant_idx, m_gidx);
    chk("err_cnt",   err_cnt,   m_err);
    for (int i = 0; i < NS; i++) if (src_pop[i]) pop_log.push_back(i);
  end

  initial begin
    int np, bubbles, guard;
    rst = 1'b1;
    BREADY = 1'b0;
    drive_fronts();
    tick(); tick();
    chk("rst_bvalid", BVALID, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_gidx", grant_idx, 0);
    rst = 1'b0;

    // Single entry on source 1.
    fq[1].push_back(ent_t'{4'h5, RESP_OKAY});
    BREADY = 1'b1;
    np = pop_log.size();
    tick();
    chk("t2_bvalid", BVALID, 1);
    chk("t2_bid", BID, 5);
    chk("t2_gidx", grant_idx, 1);
    tick();
    chk("t2_bvalid_fall", BVALID, 0);
    chk("t2_pops", pop_log.size() - np, 1);
    if (pop_log.size() > np) chk("t2_pop_src", pop_log[np], 1);

    // Pointer now sits at 2: source 3 must win before wrapping to source 1.
    fq[1].push_back(ent_t'{4'h1, RESP_OKAY});
    fq[3].push_back(ent_t'{4'h3, RESP_SLVERR});
    gnt_log.delete();
    repeat (3) begin
      tick();
      if (BVALID) gnt_log.push_back(int'(grant_idx));
    end
    chk_seq("t3_grants", gnt_log, exp_t3);
    chk("t3_err", err_cnt, 1);

    // Reset with a held response: it is discarded and nothing pops during reset.
    fq[2].push_back(ent_t'{4'h7, RESP_DECERR});
    BREADY = 1'b0;
    tick();
    chk("t4_held", BVALID, 1);
    chk("t4_gidx", grant_idx, 2);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t4_rst_bvalid", BVALID, 0);
    chk("t4_rst_err", err_cnt, 0);
    fq[3].push_back(ent_t'{4'hC, RESP_OKAY});
    np = pop_log.size();
    tick(); tick();
    chk("t4_no_pop_in_rst", pop_log.size() - np, 0);
    rst = 1'b0;
    tick();
    chk("t4_post_bvalid", BVALID, 1);
    chk("t4_post_gidx", grant_idx, 3);
    chk("t4_post_err", err_cnt, 0);
    BREADY = 1'b1;
    tick();
    chk("t4_drained", BVALID, 0);

    // All sources busy: strict rotation with no bubbles.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NS; i++)
        fq[i].push_back(ent_t'{IDW'(r * 4 + i), (i % 2) ? RESP_EXOKAY : RESP_OKAY});
    np = pop_log.size();
    gnt_log.delete();
    bubbles = 0;
    repeat (8) begin
      tick();
      gnt_log.push_back(int'(grant_idx));
      if (!BVALID) bubbles++;
    end
    chk_seq("t5_grants", gnt_log, exp_t5);
    chk("t5_bubbles", bubbles, 0);
    chk("t5_pops", pop_log.size() - np, 8);
    chk("t5_err", err_cnt, 0);
    tick();
    chk("t5_drained", BVALID, 0);

    // Stall with source 0 held while source 3 fills, then swap in the handshake cycle.
    fq[0].push_back(ent_t'{4'hA, RESP_SLVERR});
    BREADY = 1'b0;
    tick();
    chk("t6_gidx0", grant_idx, 0);
    fq[3].push_back(ent_t'{4'hB, RESP_OKAY});
    np = pop_log.size();
    repeat (5) begin
      tick();
      chk("t6_bvalid", BVALID, 1);
      chk("t6_bid", BID, 4'hA);
      chk("t6_bresp", BRESP, RESP_SLVERR);
      chk("t6_gidx", grant_idx, 0);
    end
    chk("t6_no_pop", pop_log.size() - np, 0);
    BREADY = 1'b1;
    tick();
    chk("t6_swap_bvalid", BVALID, 1);
    chk("t6_swap_bid", BID, 4'hB);
    chk("t6_swap_gidx", grant_idx, 3);
    chk("t6_err", err_cnt, 1);
    tick();
    chk("t6_drained", BVALID, 0);

    // Error counter saturation; OKAY/EXOKAY traffic interleaved.
    for (int k = 0; k < 300; k++) fq[0].push_back(ent_t'{IDW'(k), RESP_DECERR});
    for (int k = 0; k < 20; k++)  fq[1].push_back(ent_t'{IDW'(k), (k % 2) ? RESP_EXOKAY : RESP_OKAY});
    guard = 0;
    while ((fq[0].size() != 0 || fq[1].size() != 0 || m_valid) && guard < 1000) begin
      tick();
      guard++;
    end
    chk("t7_drain_in_time", guard < 1000, 1);
    chk("t7_err_sat", err_cnt, 255);
    chk("t7_model_sat", m_err, 255);
    chk("t7_bvalid", BVALID, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
